gmii_frame_gen: RTL and testbench

Parametrised GMII-side frame generator for the 1000BASE-X PCS transmit path, replacing hand-written stimulus sequences on TXD/TX_EN/TX_ER with a synthesizable, programmable source. On `start` it emits a burst of N frames (preamble, SFD, payload of programmable length and pattern) separated by a programmable inter-packet gap. It waits for the PCS `transmitting` flag to drop before starting each frame. It sits directly upstream of the PCS transmit block, in benches and in on-chip loopback self-test.

---
 rtl/gmii_gen_pkg.sv | 32 +++
 rtl/gmii_frame_gen_pattern.sv | 38 +++
 rtl/gmii_frame_gen.sv | 214 +++++++++++++++++++++
 tb/tb_gmii_frame_gen.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_gen_pkg.sv
// Shared types and constants for the GMII frame generator: FSM states,
// fixed GMII code words and the per-width LFSR tap table.
package gmii_gen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_PRE,
      ST_SFD,
      ST_DATA,
      ST_IPG,
      ST_DONE
   } state_t;

   localparam logic [7:0] PREAMBLE_WORD = 8'h55;
   localparam logic [7:0] SFD_WORD      = 8'hD5;
   localparam logic [7:0] IDLE_WORD     = 8'h00;

   // Fibonacci tap masks (bit n-1 set for term x^n); maximal-length where listed.
   function automatic logic [31:0] lfsr_taps(input int width);
      case (width)
         4:       lfsr_taps = 32'h0000_000C;
         8:       lfsr_taps = 32'h0000_00B8;
         10:      lfsr_taps = 32'h0000_0240;
         12:      lfsr_taps = 32'h0000_0829;
         16:      lfsr_taps = 32'h0000_B400;
         32:      lfsr_taps = 32'h8020_0003;
         default: lfsr_taps = (32'h1 << (width - 1)) | 32'h1;
      endcase
   endfunction

endpackage

// File: rtl/gmii_frame_gen_pattern.sv
// Payload word source: incrementing counter or Fibonacci LFSR, reloaded
// from the seed at the start of every frame.
module gmii_pattern_gen
   import gmii_gen_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              Clk,
   input  logic              mr_main_reset,
   input  logic              i_load,
   input  logic              i_advance,
   input  logic              i_sel,
   input  logic [DATA_W-1:0] i_seed,
   output logic [DATA_W-1:0] o_word
);

   localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

   logic [DATA_W-1:0] r_word;
   logic [DATA_W-1:0] w_load_val;
   logic [DATA_W-1:0] w_next;

   always_comb begin
      // An all-zero LFSR would lock up, so a zero seed starts from 1.
      w_load_val = (i_sel && (i_seed == '0)) ? DATA_W'(1) : i_seed;
      w_next     = i_sel ? {r_word[DATA_W-2:0], ^(r_word & TAPS)}
                         : r_word + DATA_W'(1);
   end

   always_ff @(posedge Clk or posedge mr_main_reset) begin
      if (mr_main_reset)  r_word <= '0;
      else if (i_load)    r_word <= w_load_val;
      else if (i_advance) r_word <= w_next;
   end

   assign o_word = r_word;

endmodule

// File: rtl/gmii_frame_gen.sv
// Programmable GMII burst source: preamble, SFD, payload and IPG per frame.
// Define GMII_GEN_ERR_INJ_EN to add err_frame/err_idx single-word TX_ER injection.
module gmii_frame_gen
   import gmii_gen_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int LEN_W        = 11,
   parameter int CNT_W        = 8,
   parameter int IPG_W        = 6,
   parameter int PREAMBLE_LEN = 7
) (
   input  logic              Clk,
   input  logic              mr_main_reset,
   input  logic              start,
   input  logic              stop,
   input  logic [CNT_W-1:0]  num_frames,
   input  logic [LEN_W-1:0]  frame_len,
   input  logic [IPG_W-1:0]  ipg,
   input  logic              pattern_sel,
   input  logic [DATA_W-1:0] seed,
`ifdef GMII_GEN_ERR_INJ_EN
   input  logic [CNT_W-1:0]  err_frame,
   input  logic [LEN_W-1:0]  err_idx,
`endif
   input  logic              transmitting,
   output logic [DATA_W-1:0] TXD,
   output logic              TX_EN,
   output logic              TX_ER,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam int CW_A = (LEN_W > IPG_W) ? LEN_W : IPG_W;
   localparam int CW_P = $clog2(PREAMBLE_LEN + 1);
   localparam int CW   = ((CW_A > CW_P) ? CW_A : CW_P) + 1;

   state_t            r_state, w_state_next;
   logic [CW-1:0]     r_cnt, w_cnt_next, w_cnt_inc;
   logic [CNT_W-1:0]  r_frames, r_frame_cnt, w_frame_cnt_next, w_frame_cnt_inc;
   logic [LEN_W-1:0]  r_len;
   logic [IPG_W-1:0]  r_ipg;
   logic              r_sel, r_stop_seen;
   logic [DATA_W-1:0] r_seed, w_word;
   logic [DATA_W-1:0] r_txd, w_txd_next;
   logic              r_tx_en, r_tx_er, r_busy, r_done;
   logic              w_tx_en_next, w_tx_er_next;
   logic              w_load, w_advance, w_err_hit, w_start_ok;

   assign w_start_ok      = (r_state == ST_IDLE) && start;
   assign w_cnt_inc       = r_cnt + CW'(1);
   assign w_frame_cnt_inc = (&r_frame_cnt) ? r_frame_cnt : r_frame_cnt + CNT_W'(1);

   gmii_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
      .Clk           (Clk),
      .mr_main_reset (mr_main_reset),
      .i_load        (w_load),
      .i_advance     (w_advance),
      .i_sel         (r_sel),
      .i_seed        (r_seed),
      .o_word        (w_word)
   );

   // Burst configuration is frozen at start; zero frame count / gap mean 1.
   always_ff @(posedge Clk or posedge mr_main_reset) begin
      if (mr_main_reset) begin
         r_frames <= '0;
         r_len    <= '0;
         r_ipg    <= '0;
         r_sel    <= 1'b0;
         r_seed   <= '0;
      end else if (w_start_ok) begin
         r_frames <= (num_frames == '0) ? CNT_W'(1) : num_frames;
         r_len    <= frame_len;
         r_ipg    <= (ipg == '0) ? IPG_W'(1) : ipg;
         r_sel    <= pattern_sel;
         r_seed   <= seed;
      end
   end

   always_ff @(posedge Clk or posedge mr_main_reset) begin
      if (mr_main_reset)             r_stop_seen <= 1'b0;
      else if (r_state == ST_IDLE)   r_stop_seen <= stop;
      else if (stop)                 r_stop_seen <= 1'b1;
   end

`ifdef GMII_GEN_ERR_INJ_EN
   logic [CNT_W-1:0] r_err_frame;
   logic [LEN_W-1:0] r_err_idx;
   logic [CW-1:0]    w_word_idx;

   always_ff @(posedge Clk or posedge mr_main_reset) begin
      if (mr_main_reset) begin
         r_err_frame <= '0;
         r_err_idx   <= '0;
      end else if (w_start_ok) begin
         r_err_frame <= err_frame;
         r_err_idx   <= err_idx;
      end
   end

   // Index of the word about to be registered onto TXD.
   assign w_word_idx = (r_state == ST_SFD) ? '0 : w_cnt_inc;
   assign w_err_hit  = (r_frame_cnt == r_err_frame) && (w_word_idx == CW'(r_err_idx));
`else
   assign w_err_hit = 1'b0;
`endif

   always_comb begin
      w_state_next     = r_state;
      w_cnt_next       = r_cnt;
      w_frame_cnt_next = r_frame_cnt;
      w_load           = 1'b0;
      w_advance        = 1'b0;
      case (r_state)
         ST_IDLE: if (start) begin
            w_state_next     = ST_WAIT;
            w_frame_cnt_next = '0;
         end
         ST_WAIT: begin
            w_load = 1'b1;
            if (!transmitting) begin
               w_state_next = ST_PRE;
               w_cnt_next   = '0;
            end
         end
         ST_PRE: begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc == CW'(PREAMBLE_LEN)) w_state_next = ST_SFD;
         end
         ST_SFD: begin
            w_cnt_next = '0;
            if (r_len == '0) begin
               w_state_next     = ST_IPG;
               w_frame_cnt_next = w_frame_cnt_inc;
            end else begin
               w_state_next = ST_DATA;
               w_advance    = 1'b1;
            end
         end
         ST_DATA: begin
            if (w_cnt_inc == CW'(r_len)) begin
               w_state_next     = ST_IPG;
               w_cnt_next       = '0;
               w_frame_cnt_next = w_frame_cnt_inc;
            end else begin
               w_cnt_next = w_cnt_inc;
               w_advance  = 1'b1;
            end
         end
         ST_IPG: begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc == CW'(r_ipg)) begin
               w_cnt_next   = '0;
               w_state_next = ((r_frame_cnt == r_frames) || r_stop_seen || stop)
                              ? ST_DONE : ST_WAIT;
            end
         end
         ST_DONE: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they register in step with it.
      w_txd_next   = DATA_W'(IDLE_WORD);
      w_tx_en_next = 1'b0;
      w_tx_er_next = 1'b0;
      case (w_state_next)
         ST_PRE: begin
            w_txd_next   = DATA_W'(PREAMBLE_WORD);
            w_tx_en_next = 1'b1;
         end
         ST_SFD: begin
            w_txd_next   = DATA_W'(SFD_WORD);
            w_tx_en_next = 1'b1;
         end
         ST_DATA: begin
            w_txd_next   = w_word;
            w_tx_en_next = 1'b1;
            w_tx_er_next = w_err_hit;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk or posedge mr_main_reset) begin
      if (mr_main_reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_frame_cnt <= '0;
         r_txd       <= '0;
         r_tx_en     <= 1'b0;
         r_tx_er     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_frame_cnt <= w_frame_cnt_next;
         r_txd       <= w_txd_next;
         r_tx_en     <= w_tx_en_next;
         r_tx_er     <= w_tx_er_next;
         r_busy      <= (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
         r_done      <= (w_state_next == ST_DONE);
      end
   end

   assign TXD       = r_txd;
   assign TX_EN     = r_tx_en;
   assign TX_ER     = r_tx_er;
   assign busy      = r_busy;
   assign done      = r_done;
   assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_gmii_frame_gen.sv
// Self-checking bench for gmii_frame_gen: cycle traces compared against a
// frame-level reference model built from the burst parameters.
module tb_gmii_frame_gen;

   localparam int DATA_W = 8;
   localparam int LEN_W  = 11;
   localparam int CNT_W  = 8;
   localparam int IPG_W  = 6;
`ifdef GMII_GEN_ERR_INJ_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic              Clk = 1'b0;
   logic              mr_main_reset, start, stop, pattern_sel, transmitting;
   logic [CNT_W-1:0]  num_frames, err_frame;
   logic [LEN_W-1:0]  frame_len, err_idx;
   logic [IPG_W-1:0]  ipg;
   logic [DATA_W-1:0] seed;
   logic [DATA_W-1:0] TXD;
   logic              TX_EN, TX_ER, busy, done;
   logic [CNT_W-1:0]  frame_cnt;

   int total = 0;
   int bad   = 0;

   // {frame_cnt, busy, done, TX_ER, TX_EN, TXD}
   typedef logic [19:0] ent_t;
   ent_t exp_q[$];
   ent_t got_q[$];

   always #5 Clk = ~Clk;

   gmii_frame_gen dut (
      .Clk           (Clk),
      .mr_main_reset (mr_main_reset),
      .start         (start),
      .stop          (stop),
      .num_frames    (num_frames),
      .frame_len     (frame_len),
      .ipg           (ipg),
      .pattern_sel   (pattern_sel),
      .seed          (seed),
`ifdef GMII_GEN_ERR_INJ_EN
      .err_frame     (err_frame),
      .err_idx       (err_idx),
`endif
      .transmitting  (transmitting),
      .TXD           (TXD),
      .TX_EN         (TX_EN),
      .TX_ER         (TX_ER),
      .busy          (busy),
      .done          (done),
      .frame_cnt     (frame_cnt)
   );

   function automatic ent_t mk(int fc, bit b, bit d, bit er, bit en, logic [7:0] txd);
      mk = {8'(fc), b, d, er, en, txd};
   endfunction

   // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB.
   function automatic logic [7:0] lfsr_step(logic [7:0] s);
      lfsr_step = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
   endfunction

   // Expected stream from the first cycle after the start edge to two cycles past DONE.
   task automatic build_expected(int frames, int len, int gap, bit sel, logic [7:0] sd,
                                 int first_wait, int ef, int ei);
      logic [7:0] w;
      int g;
      g = (gap == 0) ? 1 : gap;
      exp_q.delete();
      for (int f = 0; f < frames; f++) begin
         for (int i = 0; i < ((f == 0) ? first_wait : 1); i++) exp_q.push_back(mk(f, 1, 0, 0, 0, 8'h00));
         for (int i = 0; i < 7; i++) exp_q.push_back(mk(f, 1, 0, 0, 1, 8'h55));
         exp_q.push_back(mk(f, 1, 0, 0, 1, 8'hD5));
         w = (sel && sd == 8'h00) ? 8'h01 : sd;
         for (int i = 0; i < len; i++) begin
            exp_q.push_back(mk(f, 1, 0, ERR_EN && f == ef && i == ei, 1, w));
            w = sel ? lfsr_step(w) : w + 8'h01;
         end
         for (int i = 0; i < g; i++) exp_q.push_back(mk(f + 1, 1, 0, 0, 0, 8'h00));
      end
      exp_q.push_back(mk(frames, 0, 1, 0, 0, 8'h00));
      exp_q.push_back(mk(frames, 0, 0, 0, 0, 8'h00));
      exp_q.push_back(mk(frames, 0, 0, 0, 0, 8'h00));
   endtask

   // Pulses start and records exactly as many cycles as the model expects.
   task automatic run_burst(int hold, int stop_at, bit stop_with_start);
      got_q.delete();
      @(negedge Clk);
      start = 1'b1;
      stop = stop_with_start;
      transmitting = (hold > 1);
      @(negedge Clk);
      start = 1'b0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) @(negedge Clk);
         got_q.push_back({frame_cnt, busy, done, TX_ER, TX_EN, TXD});
         transmitting = (i < hold - 1);
         stop = (i == stop_at);
      end
      $display("burst nf=%0d len=%0d ipg=%0d sel=%0b seed=%h cycles=%0d",
               num_frames, frame_len, ipg, pattern_sel, seed, got_q.size());
   endtask

   task automatic set_cfg(int nf, int len, int gap, bit sel, logic [7:0] sd);
      num_frames  = CNT_W'(nf);
      frame_len   = LEN_W'(len);
      ipg         = IPG_W'(gap);
      pattern_sel = sel;
      seed        = sd;
   endtask

   task automatic test_reset();
      mr_main_reset = 1'b1;
      start = 0; stop = 0; transmitting = 0;
      set_cfg(0, 0, 0, 0, 8'h00);
      err_frame = '0; err_idx = '0;
      repeat (3) @(negedge Clk);
      total++; if (TXD !== 8'h00)      begin bad++; $display("FAIL reset_txd got %h want 00", TXD); end
      total++; if (TX_EN !== 1'b0)     begin bad++; $display("FAIL reset_tx_en got %b want 0", TX_EN); end
      total++; if (TX_ER !== 1'b0)     begin bad++; $display("FAIL reset_tx_er got %b want 0", TX_ER); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
      total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got %b want 0", done); end
      total++; if (frame_cnt !== 8'h0) begin bad++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
      mr_main_reset = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic test_basic();
      int dcount;
      set_cfg(2, 4, 3, 0, 8'h10);
      build_expected(2, 4, 3, 0, 8'h10, 1, -1, -1);
      run_burst(1, -1, 0);
      dcount = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         dcount += int'(got_q[i][10]);
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic cyc=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
      total++; if (dcount !== 1)         begin bad++; $display("FAIL basic_done_pulses got %0d want 1", dcount); end
      total++; if (frame_cnt !== 8'd2)   begin bad++; $display("FAIL basic_frame_cnt got %0d want 2", frame_cnt); end
   endtask

   task automatic test_lfsr();
      set_cfg(2, 5, 2, 1, 8'h01);
      build_expected(2, 5, 2, 1, 8'h01, 1, -1, -1);
      run_burst(1, -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL lfsr cyc=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_handshake_zero_len();
      set_cfg(1, 3, 1, 0, 8'hA0);
      build_expected(1, 3, 1, 0, 8'hA0, 10, -1, -1);
      run_burst(10, -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL handshake cyc=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
      set_cfg(2, 0, 0, 1, 8'h33);
      build_expected(2, 0, 0, 1, 8'h33, 1, -1, -1);
      run_burst(1, -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL zero_len cyc=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_stop();
      // Cycle 28 falls in the second frame's payload (len 6, ipg 2).
      set_cfg(5, 6, 2, 0, 8'hF0);
      build_expected(2, 6, 2, 0, 8'hF0, 1, -1, -1);
      run_burst(1, 28, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL stop cyc=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
      set_cfg(4, 2, 1, 0, 8'h05);
      build_expected(1, 2, 1, 0, 8'h05, 1, -1, -1);
      run_burst(1, -1, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL start_stop cyc=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_err_inj();
      err_frame = 8'd1; err_idx = 11'd2;
      set_cfg(3, 4, 1, 0, 8'h40);
      build_expected(3, 4, 1, 0, 8'h40, 1, 1, 2);
      run_burst(1, -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL err_in_range cyc=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
      err_frame = 8'd0; err_idx = 11'd4;
      build_expected(3, 4, 1, 0, 8'h40, 1, 0, 4);
      run_burst(1, -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL err_out_range cyc=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
      err_frame = '0; err_idx = '0;
   endtask

   task automatic test_random();
      int nf, len, gap, hold;
      bit sel;
      logic [7:0] sd;
      for (int k = 0; k < 8; k++) begin
         nf   = $urandom_range(0, 3);
         len  = $urandom_range(0, 10);
         gap  = $urandom_range(0, 5);
         hold = $urandom_range(1, 4);
         sel  = 1'($urandom_range(0, 1));
         sd   = (k == 0) ? 8'h00 : 8'($urandom);
         set_cfg(nf, len, gap, sel, sd);
         build_expected((nf == 0) ? 1 : nf, len, gap, sel, sd, hold, -1, -1);
         run_burst(hold, -1, 0);
         for (int i = 0; i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL random%0d cyc=%0d got %h want %h", k, i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      set_cfg(3, 8, 2, 0, 8'h20);
      @(negedge Clk); start = 1'b1;
      @(negedge Clk); start = 1'b0;
      repeat (30) @(negedge Clk);
      $display("reset mid-frame at cycle 30 of burst");
      total++; if (TX_EN !== 1'b1)     begin bad++; $display("FAIL pre_reset_tx_en got %b want 1", TX_EN); end
      total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL pre_reset_frame_cnt got %0d want 1", frame_cnt); end
      #2 mr_main_reset = 1'b1;
      #1;
      total++; if (TX_EN !== 1'b0)     begin bad++; $display("FAIL async_tx_en got %b want 0", TX_EN); end
      total++; if (busy !== 1'b0)      begin bad++; $display("FAIL async_busy got %b want 0", busy); end
      total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL async_frame_cnt got %0d want 0", frame_cnt); end
      @(negedge Clk); mr_main_reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         total++;
         if ({busy, TX_EN} !== 2'b00) begin bad++; $display("FAIL post_reset_idle cyc=%0d got busy/en %b want 00", i, {busy, TX_EN}); end
      end
      set_cfg(1, 2, 1, 0, 8'h77);
      build_expected(1, 2, 1, 0, 8'h77, 1, -1, -1);
      run_burst(1, -1, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL restart cyc=%0d got %h want %h", i, got_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lfsr();
      test_handshake_zero_len();
      test_stop();
      test_err_inj();
      test_random();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
